sevseg_scan_ctrl: RTL and testbench
===================================

# sevseg_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display on the FPGA top. It latches a 32-bit debug word once per frame so every frame shows one consistent value. It rotates through the eight anodes with a programmable dwell time and inserts a blanking guard at each digit change to suppress ghosting. It replaces the ad-hoc anode/segment logic at top level: its input is the `debug_output` mux, and its outputs drive `an`, `sev_out` and the decimal point.

## Interface
Parameters:
- `DWELL`, default 50000: clock cycles per digit. Legal range is ≥ 2.
- `GUARD`, default 500: cycles at the start of each dwell with all anodes off. Legal range is 0 ≤ GUARD < DWELL.

Ports:
- `clk`  in  1  system clock. This is the single clock domain.
- `Rst`  in  1  reset, asynchronous and active-high.
- `value`  in  32  word to display. Nibble i drives digit i, and digit 0 is the rightmost.
- `dp_mask`  in  8  decimal point enables, bit i for digit i, active-high. Latched together with `value`.
- `freeze`  in  1  when high, the frame-boundary reload of the shadow registers is suppressed.
- `an`  out  8  anode selects, active-low, one-hot.
- `sev_out`  out  7  segments {a,b,c,d,e,f,g}, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Dwell counter `cnt`**: counts 0..DWELL-1, then wraps to 0.
- **Digit index `idx`**: 3 bits. Increments when `cnt == DWELL-1` and wraps from 7 to 0.
- **Frame boundary**: the cycle where `cnt == DWELL-1 && idx == 7`.
  - `frame_done` pulses in that cycle, whether or not `freeze` is high.
  - If `freeze` is low, `shadow_val <= value` and `shadow_dp <= dp_mask` on that edge.
  - If `freeze` is high, the shadows hold. `freeze` wins over a boundary.
- **Mid-frame input changes**: changes to `value` or `dp_mask` are invisible until the next unfrozen boundary.
- **Output decode**, registered from the current `cnt`, `idx` and shadows:
  - Guard (`cnt < GUARD`): `an = 8'hFF`, `sev_out = 7'h7F`, `dp = 1`.
  - Otherwise: `an = ~(8'b1 << idx)`, `sev_out = hex7(shadow_val[4*idx +: 4])`, `dp = ~shadow_dp[idx]`.
- **`hex7` table**, values 0..F:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, B = 1100000
  - C = 0110001, D = 1000010, E = 0110000, F = 0111000
- **State machine**: two phases per digit, GUARD then SHOW. There are 8 digits per frame, giving a frame period of 8·DWELL cycles.
- **GUARD = 0**: no guard phase. The anode switches directly between digits.

## Timing
- **Reset values** (asynchronous, immediate, including mid-frame):
  - `cnt = 0`, `idx = 0`, `shadow_val = 0`, `shadow_dp = 0`
  - `an = 8'hFF`, `sev_out = 7'h7F`, `dp = 1`, `frame_done = 0`
- **Output latency**: outputs lag `cnt`/`idx` by one clock. The first SHOW of digit 0 appears on the edge after `cnt` reaches GUARD.
- **First frame**: shows 00000000 (the shadow reset value). The first load happens at edge 8·DWELL after reset release.
- **`frame_done`**: registered, high for exactly one cycle per 8·DWELL. It is asserted on the same edge the shadow loads.
- **Anodes**: never more than one anode is low in any cycle.

## Configuration
- Macro `SEVSEG_LZB_EN` enables leading-zero blanking.
- **Defined**: digit i (i ≥ 1) is blanked when nibbles i..7 of `shadow_val` are all zero.
  - A blanked digit shows `an` = all ones and `sev_out = 7'h7F` for the whole dwell.
  - Its `dp` is still driven from `shadow_dp[i]`, and its anode stays enabled only if that bit is set.
  - Digit 0 is never blanked.
- **Undefined**: all eight digits are always shown, including leading zeros.

## Test plan
- **Reset**: DWELL=8, GUARD=2, assert `Rst` mid-digit → same-cycle `an = FF`, `sev_out = 7F`, `dp = 1`, `frame_done = 0`. After release, `an` goes to FE three edges later.
- **Scan order**: `value = 32'h76543210`, wait one frame, observe the next frame.
  - `an` sequence is FE, FD, FB, F7, EF, DF, BF, 7F, each held 6 cycles after 2 guard cycles.
  - `sev_out` for digits 0..7 is 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111.
- **Frame consistency**: change `value` from 32'h11111111 to 32'h22222222 while idx = 3 → the rest of the frame still shows 1. The next frame shows 2. `frame_done` pulses exactly once per 64 cycles.
- **Freeze**: hold `freeze` = 1 across a boundary with `value = 32'hABCDEF01` → the display keeps the old value and `frame_done` still pulses. Drop `freeze` → the new value appears the following frame.
- **Decimal point**: `dp_mask = 8'h81` → `dp = 0` only during SHOW of digits 0 and 7, and `dp = 1` in all guard cycles.
- **Blanking** (`SEVSEG_LZB_EN`): `value = 32'h000000A5` → digits 2..7 show `an` all ones and `sev_out = 7F`. Digits 0 and 1 show 5 and A. With the macro undefined, digits 2..7 show 0000001.

Source files
------------

// File: rtl/sevseg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with per-frame shadow latching and anode guard blanking.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module sevseg_scan_ctrl #(
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  sev_out,
  output logic        dp,
  output logic        frame_done
);

  localparam int              CW      = $clog2(DWELL);
  localparam logic [CW-1:0]   LAST    = CW'(DWELL - 1);
  localparam logic [CW-1:0]   GUARD_C = CW'(GUARD);

  localparam logic [0:0] PH_GUARD = 1'b0;
  localparam logic [0:0] PH_SHOW  = 1'b1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow_val;
  logic [7:0]    shadow_dp;
  logic [0:0]    phase;
  logic          wrap;
  logic          boundary;
  logic [7:0]    blank;
  logic [7:0]    an_nxt;
  logic [6:0]    sev_nxt;
  logic          dp_nxt;

  assign wrap     = (cnt == LAST);
  assign boundary = wrap && (idx == 3'd7);

  // With no guard cycles the phase is permanently SHOW, avoiding a constant compare.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign phase = PH_SHOW;
    end else begin : g_guard
      assign phase = (cnt < GUARD_C) ? PH_GUARD : PH_SHOW;
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadows reload only at an unfrozen frame boundary so a whole frame shows one value.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (boundary && !freeze) begin
      shadow_val <= value;
      shadow_dp  <= dp_mask;
    end
  end

`ifdef SEVSEG_LZB_EN
  // Digit i is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    blank = '0;
    for (int i = 1; i < 8; i++) begin
      blank[i] = ((shadow_val >> (4 * i)) == 32'd0);
    end
  end
`else
  assign blank = 8'h00;
`endif

  always_comb begin
    an_nxt  = 8'hFF;
    sev_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (phase == PH_SHOW) begin
      dp_nxt = ~shadow_dp[idx];
      if (blank[idx]) begin
        an_nxt = shadow_dp[idx] ? ~(8'b1 << idx) : 8'hFF;
      end else begin
        an_nxt  = ~(8'b1 << idx);
        sev_nxt = hex7(shadow_val[{idx, 2'b00} +: 4]);
      end
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      an         <= 8'hFF;
      sev_out    <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      sev_out    <= sev_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed self-checking bench for sevseg_scan_ctrl with DWELL=8, GUARD=2 (64-cycle frames).
// Leading-zero expectations follow SEVSEG_LZB_EN when it is defined for the build.
module tb_sevseg_scan_ctrl;

  localparam int DWELL = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 8 * DWELL;

  logic        clk;
  logic        Rst;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        freeze;
  logic [7:0]  an;
  logic [6:0]  sev_out;
  logic        dp;
  logic        frame_done;

  int compared;
  int mismatched;

  sevseg_scan_ctrl #(.DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .value      (value),
    .dp_mask    (dp_mask),
    .freeze     (freeze),
    .an         (an),
    .sev_out    (sev_out),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'h0: seg_of = 7'b0000001;
      4'h1: seg_of = 7'b1001111;
      4'h2: seg_of = 7'b0010010;
      4'h3: seg_of = 7'b0000110;
      4'h4: seg_of = 7'b1001100;
      4'h5: seg_of = 7'b0100100;
      4'h6: seg_of = 7'b0100000;
      4'h7: seg_of = 7'b0001111;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0000100;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b1100000;
      4'hC: seg_of = 7'b0110001;
      4'hD: seg_of = 7'b1000010;
      4'hE: seg_of = 7'b0110000;
      default: seg_of = 7'b0111000;
    endcase
  endfunction

  // Checks the 64 samples of one frame, starting right after a frame_done sample.
  task automatic run_frame(input logic [31:0] exp_val, input logic [7:0] exp_dpm,
                           input int change_k, input logic [31:0] new_val, input string name);
    int d;
    int c;
    logic blk;
    logic [7:0] e_an;
    logic [6:0] e_sev;
    logic e_dp;
    logic e_fd;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      d = k / DWELL;
      c = k % DWELL;
      e_an  = 8'hFF;
      e_sev = 7'h7F;
      e_dp  = 1'b1;
      e_fd  = (k == FRAME - 1);
      if (c >= GUARD) begin
        blk = 1'b0;
`ifdef SEVSEG_LZB_EN
        blk = (d >= 1) && ((exp_val >> (4 * d)) == 32'd0);
`endif
        e_dp = ~exp_dpm[d];
        if (blk) begin
          e_an = exp_dpm[d] ? ~(8'h01 << d) : 8'hFF;
        end else begin
          e_an  = ~(8'h01 << d);
          e_sev = seg_of(exp_val[4*d +: 4]);
        end
      end
      compared += 4;
      if (an !== e_an) begin
        mismatched++;
        $display("[TB] FAIL %s an k=%0d: got %h expected %h", name, k, an, e_an);
      end
      if (sev_out !== e_sev) begin
        mismatched++;
        $display("[TB] FAIL %s sev_out k=%0d: got %b expected %b", name, k, sev_out, e_sev);
      end
      if (dp !== e_dp) begin
        mismatched++;
        $display("[TB] FAIL %s dp k=%0d: got %b expected %b", name, k, dp, e_dp);
      end
      if (frame_done !== e_fd) begin
        mismatched++;
        $display("[TB] FAIL %s frame_done k=%0d: got %b expected %b", name, k, frame_done, e_fd);
      end
      compared++;
      if ($countones(~an) > 1) begin
        mismatched++;
        $display("[TB] FAIL %s onehot k=%0d: got an=%h expected at most one low", name, k, an);
      end
      if (k == change_k) value = new_val;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'hFF;
    exp_seq[1] = 8'hFF;
    exp_seq[2] = 8'hFE;
    #2;
    compared++;
    if ({an, sev_out, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_initial: got an=%h sev=%h dp=%b fd=%b expected FF 7F 1 0",
               an, sev_out, dp, frame_done);
    end
    @(negedge clk);
    Rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      compared++;
      if (an !== exp_seq[n]) begin
        mismatched++;
        $display("[TB] FAIL reset_release an edge %0d: got %h expected %h", n + 1, an, exp_seq[n]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    Rst = 1'b1;
    #1;
    compared++;
    if ({an, sev_out, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_midframe: got an=%h sev=%h dp=%b fd=%b expected FF 7F 1 0",
               an, sev_out, dp, frame_done);
    end
    @(negedge clk);
    Rst = 1'b0;
  endtask

  task automatic test_first_frame();
    int count;
    count = 0;
    while (count < 200) begin
      @(negedge clk);
      count++;
      if (count == 3) begin
        compared++;
        if (an !== 8'hFE || sev_out !== 7'b0000001) begin
          mismatched++;
          $display("[TB] FAIL first_frame_zero: got an=%h sev=%b expected FE 0000001", an, sev_out);
        end
      end
      if (frame_done === 1'b1) break;
    end
    compared++;
    if (count != FRAME) begin
      mismatched++;
      $display("[TB] FAIL first_load_edge: got %0d expected %0d", count, FRAME);
    end
  endtask

  task automatic test_scan();
    run_frame(32'h76543210, 8'h00, -1, 32'h0, "scan");
  endtask

  task automatic test_frame_consistency();
    value = 32'h11111111;
    run_frame(32'h76543210, 8'h00, -1, 32'h0, "consist_pre");
    run_frame(32'h11111111, 8'h00, 3 * DWELL, 32'h22222222, "consist_mid");
    run_frame(32'h22222222, 8'h00, -1, 32'h0, "consist_next");
  endtask

  task automatic test_freeze();
    value  = 32'hABCDEF01;
    freeze = 1'b1;
    run_frame(32'h22222222, 8'h00, -1, 32'h0, "freeze_hold");
    freeze = 1'b0;
    run_frame(32'h22222222, 8'h00, -1, 32'h0, "freeze_still_old");
    run_frame(32'hABCDEF01, 8'h00, -1, 32'h0, "freeze_released");
  endtask

  task automatic test_dp();
    dp_mask = 8'h81;
    run_frame(32'hABCDEF01, 8'h00, -1, 32'h0, "dp_load");
    run_frame(32'hABCDEF01, 8'h81, -1, 32'h0, "dp_show");
  endtask

  task automatic test_blank();
    value   = 32'h000000A5;
    dp_mask = 8'h00;
    run_frame(32'hABCDEF01, 8'h81, -1, 32'h0, "blank_load");
    run_frame(32'h000000A5, 8'h00, -1, 32'h0, "blank_show");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Rst        = 1'b1;
    value      = 32'h76543210;
    dp_mask    = 8'h00;
    freeze     = 1'b0;
    test_reset();
    test_first_frame();
    test_scan();
    test_frame_consistency();
    test_freeze();
    test_dp();
    test_blank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
